// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Time-multiplexes six 7-segment digit codes onto one shared segment bus.
// Each digit slot opens with a blanking gap to prevent ghosting, then lights
// one anode. All six codes are captured together once per frame so that a
// frame never mixes old and new digits. Also handles optional hour-tens
// leading-zero blanking and a slowly blinking separator decimal point.
module seg_scan_mux #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 250,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       lz_blank,
    input  logic [6:0] seg_sec_unit,
    input  logic [6:0] seg_sec_tens,
    input  logic [6:0] seg_min_unit,
    input  logic [6:0] seg_min_tens,
    input  logic [6:0] seg_hour_unit,
    input  logic [6:0] seg_hour_tens,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [5:0] an_out,
    output logic       frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t          r_state;
    logic [2:0]      r_digit;
    logic [CW-1:0]   r_slotCnt;
    logic [FW-1:0]   r_frameCnt;
    logic            r_blinkPh;
    logic [5:0][6:0] r_snap;

    logic            w_snapTake;
    logic            w_blankEnd;
    logic            w_slotEnd;
    logic [6:0]      w_curSeg;
    logic            w_lit;
    logic            w_lzHide;
    logic [6:0]      w_segNext;
    logic            w_dpNext;
    logic [5:0]      w_anNext;

    // Decode slot boundaries, pick the snapshot digit, and form the next pin values
    always_comb begin
        w_snapTake = (r_state == ST_BLANK) && (r_digit == 3'd0) && (r_slotCnt == '0);
        w_blankEnd = (r_state == ST_BLANK) && (r_slotCnt == CW'(BLANK_CYCLES - 1));
        w_slotEnd  = (r_state == ST_ON) && (r_slotCnt == CW'(SCAN_DIV - 1));
        case (r_digit)
            3'd0:    w_curSeg = r_snap[0];
            3'd1:    w_curSeg = r_snap[1];
            3'd2:    w_curSeg = r_snap[2];
            3'd3:    w_curSeg = r_snap[3];
            3'd4:    w_curSeg = r_snap[4];
            3'd5:    w_curSeg = r_snap[5];
            default: w_curSeg = 7'h00;
        endcase
        w_lit     = (r_state == ST_ON) && en;
        w_lzHide  = lz_blank && (r_digit == 3'd5) && (w_curSeg == 7'h3F);
        w_segNext = w_lit ? w_curSeg : 7'h00;
        w_dpNext  = w_lit && r_blinkPh && ((r_digit == 3'd2) || (r_digit == 3'd4));
        w_anNext  = (w_lit && !w_lzHide) ? (6'd1 << r_digit) : 6'd0;
    end

    // Slot/digit scan FSM, frame counter, blink phase and per-frame snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_BLANK;
            r_digit     <= 3'd0;
            r_slotCnt   <= '0;
            r_frameCnt  <= '0;
            r_blinkPh   <= 1'b0;
            r_snap      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_snapTake;
            if (w_snapTake) begin
                r_snap <= {seg_hour_tens, seg_hour_unit, seg_min_tens,
                           seg_min_unit, seg_sec_tens, seg_sec_unit};
            end
            case (r_state)
                ST_BLANK: begin
                    r_slotCnt <= r_slotCnt + 1'b1;
                    if (w_blankEnd) begin
                        r_state <= ST_ON;
                    end
                end
                ST_ON: begin
                    if (w_slotEnd) begin
                        r_slotCnt <= '0;
                        r_state   <= ST_BLANK;
                        if (r_digit == 3'd5) begin
                            r_digit <= 3'd0;
                            if (r_frameCnt == FW'(BLINK_FRAMES - 1)) begin
                                r_frameCnt <= '0;
                                r_blinkPh  <= ~r_blinkPh;
                            end else begin
                                r_frameCnt <= r_frameCnt + 1'b1;
                            end
                        end else begin
                            r_digit <= r_digit + 3'd1;
                        end
                    end else begin
                        r_slotCnt <= r_slotCnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_BLANK;
                    r_slotCnt <= '0;
                end
            endcase
        end
    end

    // Register the pins from the current FSM state, applying output polarity
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out <= {7{SEG_ACT_LOW}};
            dp_out  <= SEG_ACT_LOW;
            an_out  <= {6{AN_ACT_LOW}};
        end else begin
            seg_out <= w_segNext ^ {7{SEG_ACT_LOW}};
            dp_out  <= w_dpNext ^ SEG_ACT_LOW;
            an_out  <= w_anNext ^ {6{AN_ACT_LOW}};
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux
// Drives seg_scan_mux with directed stimulus (SCAN_DIV=8, BLANK_CYCLES=2,
// BLINK_FRAMES=2, active-low pins). For every clock the stimulus side works
// out the expected pin values from a cycle-count view of the scan and queues
// them; a separate monitor pops and compares on the falling edge.
module tb_seg_scan_mux;

    localparam int SDIV  = 8;
    localparam int BLNK  = 2;
    localparam int FRAME = 6 * SDIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       lzBlank = 1'b0;
    logic [6:0] digIn [6];
    logic [6:0] segOut;
    logic       dpOut;
    logic [5:0] anOut;
    logic       frameStart;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [5:0] an;
        logic       fs;
        int         phase;
        int         cyc;
    } exp_t;

    exp_t       expQ [$];
    logic [6:0] modelSnap [6];
    int         cyc = 0;
    int         phase = 0;
    int         vecCount = 0;
    int         missCount = 0;

    seg_scan_mux #(
        .SCAN_DIV    (SDIV),
        .BLANK_CYCLES(BLNK),
        .BLINK_FRAMES(2),
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .lz_blank     (lzBlank),
        .seg_sec_unit (digIn[0]),
        .seg_sec_tens (digIn[1]),
        .seg_min_unit (digIn[2]),
        .seg_min_tens (digIn[3]),
        .seg_hour_unit(digIn[4]),
        .seg_hour_tens(digIn[5]),
        .seg_out      (segOut),
        .dp_out       (dpOut),
        .an_out       (anOut),
        .frame_start  (frameStart)
    );

    // 100 MHz style free-running clock
    always #5 clk = ~clk;

    // Work out what the pins should show after the coming edge, clock it, queue it
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            int   d;
            int   k;
            int   f;
            logic blink;
            logic lit;
            e.phase = phase;
            e.cyc   = cyc;
            if (rst) begin
                e.seg = 7'h7F;
                e.dp  = 1'b1;
                e.an  = 6'h3F;
                e.fs  = 1'b0;
                cyc   = 0;
            end else begin
                if ((cyc % FRAME) == 0) begin
                    for (int j = 0; j < 6; j++) modelSnap[j] = digIn[j];
                end
                d     = (cyc / SDIV) % 6;
                k     = cyc % SDIV;
                f     = cyc / FRAME;
                blink = ((f / 2) % 2) == 1;
                lit   = (k >= BLNK) && en;
                e.seg = lit ? ~modelSnap[d] : 7'h7F;
                e.dp  = (lit && blink && (d == 2 || d == 4)) ? 1'b0 : 1'b1;
                if (lit && !(lzBlank && d == 5 && modelSnap[5] == 7'h3F))
                    e.an = ~(6'd1 << d);
                else
                    e.an = 6'h3F;
                e.fs  = ((cyc % FRAME) == 0);
                cyc   = cyc + 1;
            end
            @(posedge clk);
            #1;
            expQ.push_back(e);
        end
    endtask

    // Compare one queued expectation against the pins
    task automatic checkOutput(input exp_t e);
        vecCount++;
        if (segOut !== e.seg || dpOut !== e.dp || anOut !== e.an || frameStart !== e.fs) begin
            missCount++;
            $display("[TB] FAIL pins phase%0d cyc%0d: got seg=%h dp=%b an=%h fs=%b, want seg=%h dp=%b an=%h fs=%b",
                     e.phase, e.cyc, segOut, dpOut, anOut, frameStart, e.seg, e.dp, e.an, e.fs);
        end
    endtask

    // Monitor: whenever an expectation is waiting, check it mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // Directed scenario: reset, scan order, coherence, blink, LZ blank, en and mid-slot reset
    initial begin
        digIn[0] = 7'h06;
        digIn[1] = 7'h5B;
        digIn[2] = 7'h4F;
        digIn[3] = 7'h66;
        digIn[4] = 7'h6D;
        digIn[5] = 7'h7D;
        for (int j = 0; j < 6; j++) modelSnap[j] = 7'h00;

        phase = 1;
        rst = 1'b1;
        applyStimulus(5);

        phase = 2;
        rst = 1'b0;
        applyStimulus(60);

        phase = 3;
        digIn[2] = 7'h07;
        applyStimulus(36);

        phase = 4;
        applyStimulus(96);

        phase = 5;
        digIn[5] = 7'h3F;
        lzBlank = 1'b1;
        applyStimulus(96);
        lzBlank = 1'b0;
        applyStimulus(48);

        phase = 6;
        applyStimulus(10);
        en = 1'b0;
        applyStimulus(20);
        en = 1'b1;
        applyStimulus(44);

        phase = 7;
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        digIn[0] = 7'h3F;
        applyStimulus(60);

        repeat (3) @(negedge clk);
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
